// File: rtl/psum_accum_unit_pkg.sv
// Shared types and helpers for the partial-sum accumulator: FSM state encoding and
// the signed saturation limits used by every lane.
package psum_accum_unit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_ACC_RD = 3'd2,
      ST_ACC_WR = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   function automatic int lane_max(int bw);
      return (1 << (bw - 1)) - 1;
   endfunction

   function automatic int lane_min(int bw);
      return -(1 << (bw - 1));
   endfunction

endpackage

// File: rtl/psum_accum_unit_if.sv
// OFIFO stream and single-port psum SRAM bus of the accumulator. The master side is
// the accumulator (consumes vectors, drives the SRAM); the slave side is its environment.
interface psum_accum_unit_if #(
   parameter int col     = 8,
   parameter int psum_bw = 13,
   parameter int ADDR_W  = 11
);
   localparam int VEC_W = col * psum_bw;

   logic              in_valid;
   logic              in_ready;
   logic [VEC_W-1:0]  in_data;
   logic              mem_cen;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [VEC_W-1:0]  mem_d;
   logic [VEC_W-1:0]  mem_q;

   modport master (
      input  in_valid, in_data, mem_q,
      output in_ready, mem_cen, mem_wen, mem_addr, mem_d
   );

   modport slave (
      output in_valid, in_data, mem_q,
      input  in_ready, mem_cen, mem_wen, mem_addr, mem_d
   );
endinterface

// File: rtl/psum_sat_add_lane.sv
// One lane of the accumulator: signed add of stored and incoming partial sums,
// clamped to the lane's representable range, flagging any clamp.
module psum_sat_add_lane
   import psum_accum_unit_pkg::*;
#(
   parameter int PSUM_BW = 13
) (
   input  logic signed [PSUM_BW-1:0] a,
   input  logic signed [PSUM_BW-1:0] b,
   output logic signed [PSUM_BW-1:0] sum,
   output logic                      ovf
);
   localparam logic signed [PSUM_BW:0] MAX_V = (PSUM_BW + 1)'(lane_max(PSUM_BW));
   localparam logic signed [PSUM_BW:0] MIN_V = (PSUM_BW + 1)'(lane_min(PSUM_BW));

   logic signed [PSUM_BW:0] wide;

   // NOTE: combinational blocks use blocking '=' and assign every output a default
   // first, so no path can leave a value unassigned and infer a latch.
   always_comb begin
      wide = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
      sum  = wide[PSUM_BW-1:0];
      ovf  = 1'b0;
      if (wide > MAX_V) begin
         sum = MAX_V[PSUM_BW-1:0];
         ovf = 1'b1;
      end else if (wide < MIN_V) begin
         sum = MIN_V[PSUM_BW-1:0];
         ovf = 1'b1;
      end
   end
endmodule

// File: rtl/psum_accum_unit.sv
// Partial-sum accumulator: pass 0 written straight to SRAM, later passes read-modify-written
// with per-lane saturation. Optional feature macro: PSUM_ACC_RELU_EN (ReLU on the final pass).
module psum_accum_unit
   import psum_accum_unit_pkg::*;
#(
   parameter int col     = 8,
   parameter int psum_bw = 13,
   parameter int ADDR_W  = 11,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_nij,
   input  logic [CNT_W-1:0]  num_kij,
   input  logic [ADDR_W-1:0] base_addr,
   psum_accum_unit_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              ovf
);
   localparam int VEC_W = col * psum_bw;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  nij_q, nij_d, kij_q, kij_d;
   logic [CNT_W-1:0]  num_nij_q, num_nij_d, num_kij_q, num_kij_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [VEC_W-1:0]  held_q, held_d;
   logic              ovf_q, ovf_d;

   logic [VEC_W-1:0]  sum_vec, wr_vec;
   logic [col-1:0]    lane_ovf;
   logic [ADDR_W-1:0] addr;
   logic              last_nij, last_kij;

   for (genvar g = 0; g < col; g++) begin : g_lane
      psum_sat_add_lane #(.PSUM_BW(psum_bw)) u_lane (
         .a   (bus.mem_q[g*psum_bw +: psum_bw]),
         .b   (held_q[g*psum_bw +: psum_bw]),
         .sum (sum_vec[g*psum_bw +: psum_bw]),
         .ovf (lane_ovf[g])
      );
   end

   always_comb begin
      last_nij = (nij_q == num_nij_q - 1'b1);
      last_kij = (kij_q == num_kij_q - 1'b1);
      addr     = base_q + ADDR_W'(nij_q);
      wr_vec   = (state_q == ST_FILL) ? bus.in_data : sum_vec;
`ifdef PSUM_ACC_RELU_EN
      // In FILL kij is 0, so this also covers the single-pass case.
      if (last_kij) begin
         for (int i = 0; i < col; i++) begin
            if (wr_vec[i*psum_bw + psum_bw - 1]) wr_vec[i*psum_bw +: psum_bw] = '0;
         end
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      nij_d        = nij_q;
      kij_d        = kij_q;
      num_nij_d    = num_nij_q;
      num_kij_d    = num_kij_q;
      base_d       = base_q;
      held_d       = held_q;
      ovf_d        = ovf_q;
      bus.in_ready = 1'b0;
      bus.mem_cen  = 1'b1;
      bus.mem_wen  = 1'b1;
      bus.mem_addr = '0;
      bus.mem_d    = '0;
      busy         = (state_q != ST_IDLE);
      done         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_nij_d = num_nij;
               num_kij_d = num_kij;
               base_d    = base_addr;
               nij_d     = '0;
               kij_d     = '0;
               ovf_d     = 1'b0;
               state_d   = (num_nij == '0 || num_kij == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               bus.mem_cen  = 1'b0;
               bus.mem_wen  = 1'b0;
               bus.mem_addr = addr;
               bus.mem_d    = wr_vec;
               if (last_nij) begin
                  nij_d = '0;
                  if (num_kij_q == CNT_W'(1)) begin
                     state_d = ST_DONE;
                  end else begin
                     kij_d   = CNT_W'(1);
                     state_d = ST_ACC_RD;
                  end
               end else begin
                  nij_d = nij_q + 1'b1;
               end
            end
         end
         ST_ACC_RD: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               bus.mem_cen  = 1'b0;
               bus.mem_addr = addr;
               held_d       = bus.in_data;
               state_d      = ST_ACC_WR;
            end
         end
         ST_ACC_WR: begin
            // mem_q now holds the word read last cycle from this same address.
            bus.mem_cen  = 1'b0;
            bus.mem_wen  = 1'b0;
            bus.mem_addr = addr;
            bus.mem_d    = wr_vec;
            if (|lane_ovf) ovf_d = 1'b1;
            state_d = ST_ACC_RD;
            if (last_nij) begin
               nij_d = '0;
               if (last_kij) state_d = ST_DONE;
               else          kij_d   = kij_q + 1'b1;
            end else begin
               nij_d = nij_q + 1'b1;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A reset cycle must not touch the SRAM, even mid-transaction.
      if (reset) begin
         bus.in_ready = 1'b0;
         bus.mem_cen  = 1'b1;
         bus.mem_wen  = 1'b1;
         bus.mem_addr = '0;
         bus.mem_d    = '0;
         busy         = 1'b0;
         done         = 1'b0;
      end
   end

   // NOTE: synchronous active-high reset with non-blocking '<='; the small held
   // vector register is reset too so no stale data survives an abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         nij_q     <= '0;
         kij_q     <= '0;
         num_nij_q <= '0;
         num_kij_q <= '0;
         base_q    <= '0;
         held_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         nij_q     <= nij_d;
         kij_q     <= kij_d;
         num_nij_q <= num_nij_d;
         num_kij_q <= num_kij_d;
         base_q    <= base_d;
         held_q    <= held_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ovf = ovf_q;
endmodule

// File: tb/tb_psum_accum_unit.sv
// Scoreboard bench for psum_accum_unit: directed passes push expected SRAM writes,
// a monitor compares every write the DUT issues against the queue.
module tb_psum_accum_unit;
   localparam int COL = 8;
   localparam int BW  = 13;
   localparam int AW  = 11;
   localparam int CW  = 8;
   localparam int VW  = COL * BW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [VW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] num_nij = '0;
   logic [CW-1:0] num_kij = '0;
   logic [AW-1:0] base_addr = '0;
   logic          busy, done, ovf;

   psum_accum_unit_if #(.col(COL), .psum_bw(BW), .ADDR_W(AW)) bus ();

   psum_accum_unit #(.col(COL), .psum_bw(BW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .num_nij   (num_nij),
      .num_kij   (num_kij),
      .base_addr (base_addr),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   logic [VW-1:0] sram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.mem_cen === 1'b0) begin
         if (bus.mem_wen === 1'b0) sram[bus.mem_addr] <= bus.mem_d;
         else                      bus.mem_q <= sram[bus.mem_addr];
      end
   end

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  access_cnt = 0;

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor samples just before each active edge, i.e. what the SRAM will latch.
   wr_t mon_e;
   always @(negedge clk) begin
      #4;
      if (bus.mem_cen === 1'b0) access_cnt++;
      if (bus.mem_cen === 1'b0 && bus.mem_wen === 1'b0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                     bus.mem_addr, bus.mem_d);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 128'(bus.mem_addr), 128'(mon_e.addr));
            check("wr_data", 128'(bus.mem_d), 128'(mon_e.data));
         end
      end
   end

   function automatic logic [VW-1:0] lanes(int l0, int l1, int rest);
      logic [VW-1:0] r;
      for (int i = 0; i < COL; i++)
         r[i*BW +: BW] = BW'((i == 0) ? l0 : (i == 1) ? l1 : rest);
      return r;
   endfunction

   function automatic logic [VW-1:0] splat(int v);
      return lanes(v, v, v);
   endfunction

   task automatic expect_wr(int addr, logic [VW-1:0] data);
      wr_t e;
      e.addr = AW'(addr);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic do_start(int n, int k, int base);
      @(negedge clk);
      start     = 1'b1;
      num_nij   = CW'(n);
      num_kij   = CW'(k);
      base_addr = AW'(base);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns at the negedge after the accepting edge; waited = cycles spent with in_ready low.
   task automatic send_vec(logic [VW-1:0] data, output int waited);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      waited = 0;
      while (!bus.in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1 within 20 cycles");
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(int exp_lat);
      int cyc = 1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("done_latency", 128'(cyc), 128'(exp_lat));
      @(negedge clk);
      check("done_one_cycle", {done, busy}, 2'b00);
   endtask

   initial begin
      int w, wsum, acc0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      repeat (3) @(negedge clk);
      check("rst_outputs",
            {bus.in_ready, bus.mem_cen, bus.mem_wen, busy, done, ovf},
            6'b011000);
      check("rst_addr_d", {bus.mem_addr, bus.mem_d}, '0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_after_rst", {bus.in_ready, bus.mem_cen, busy, done}, 4'b0100);

      // Single pass: every vector written directly, in_ready stays high.
      do_start(4, 1, 'h10);
      wsum = 0;
      for (int i = 0; i < 4; i++) begin
         expect_wr('h10 + i, splat(i + 1));
         send_vec(splat(i + 1), w);
         wsum += w;
      end
      check("fill_no_stall", 128'(wsum), 0);
      wait_done(1);

      // Three passes of +5: 5, 10, 15; a stray start mid-run is ignored.
      do_start(3, 3, 'h20);
      wsum = 0;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 3; i++) expect_wr('h20 + i, splat(5 * (p + 1)));
      for (int i = 0; i < 3; i++) begin
         send_vec(splat(5), w);
         wsum += w;
      end
      check("fill3_no_stall", 128'(wsum), 0);
      start = 1'b1; num_nij = 8'd1; num_kij = 8'd1; base_addr = 11'h300;
      @(negedge clk);
      start = 1'b0;
      wsum = 0;
      for (int i = 0; i < 6; i++) begin
         send_vec(splat(5), w);
         wsum += w;
      end
      check("acc_ready_toggle", 128'(wsum), 5);
      wait_done(2);
      check("ovf_clear_after_acc", 128'(ovf), 0);

      // Saturation on lane 0 both directions, lanes 1..7 ordinary.
      do_start(2, 2, 'h40);
      expect_wr('h40, lanes(4090, 1, 1));
      expect_wr('h41, lanes(-4090, -1, -1));
      expect_wr('h40, lanes(4095, 2, 2));
      expect_wr('h41, lanes(-4096, -2, -2));
      send_vec(lanes(4090, 1, 1), w);
      send_vec(lanes(-4090, -1, -1), w);
      send_vec(lanes(10, 1, 1), w);
      send_vec(lanes(-10, -1, -1), w);
      wait_done(2);
      check("ovf_set_on_clamp", 128'(ovf), 1);

      // Exact upper limit is not a clamp; start clears ovf.
      do_start(1, 2, 'h50);
      check("ovf_cleared_by_start", 128'(ovf), 0);
      expect_wr('h50, splat(4085));
      expect_wr('h50, splat(4095));
      send_vec(splat(4085), w);
      send_vec(splat(10), w);
      wait_done(2);
      check("ovf_exact_max", 128'(ovf), 0);

      // Address wrap at the top of the SRAM.
      do_start(4, 1, 'h7FE);
      expect_wr('h7FE, splat(100));
      expect_wr('h7FF, splat(101));
      expect_wr('h000, splat(102));
      expect_wr('h001, splat(103));
      for (int i = 0; i < 4; i++) send_vec(splat(100 + i), w);
      wait_done(1);

      // Zero counts: straight to DONE without touching the SRAM.
      acc0 = access_cnt;
      do_start(0, 3, 'h60);
      check("zero_nij_busy", 128'(busy), 1);
      wait_done(1);
      do_start(2, 0, 'h60);
      wait_done(1);
      check("zero_no_access", 128'(access_cnt), 128'(acc0));

      // Final-pass ReLU on lane 0 (-10 + 3 = -7); lane 1 stays positive.
      do_start(1, 2, 'h70);
      expect_wr('h70, lanes(-10, 4, 0));
`ifdef PSUM_ACC_RELU_EN
      expect_wr('h70, lanes(0, 9, 0));
`else
      expect_wr('h70, lanes(-7, 9, 0));
`endif
      send_vec(lanes(-10, 4, 0), w);
      send_vec(lanes(3, 5, 0), w);
      wait_done(2);

      // Reset during the pass-2 write: no write, machine idles, next run is clean.
      do_start(2, 3, 'h80);
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 2; i++) expect_wr('h80 + i, splat(p + 1));
      for (int i = 0; i < 4; i++) send_vec(splat(1), w);
      send_vec(splat(1), w);
      check("in_accwr_before_rst", {bus.in_ready, busy}, 2'b01);
      reset = 1'b1;
      @(negedge clk);
      check("rst_abort", {bus.mem_cen, busy, bus.in_ready}, 3'b100);
      reset = 1'b0;
      @(negedge clk);
      check("idle_after_abort", {bus.mem_cen, busy}, 2'b10);
      do_start(1, 1, 'h90);
      expect_wr('h90, splat(42));
      send_vec(splat(42), w);
      wait_done(1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 128'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
